// File: rtl/core_rsp_queue.sv
// Per-bank core response queue: in-order, first-word-fall-through circular buffer
// that captures one multi-port bank response per cycle and flags almost-full early.
module core_rsp_queue #(
    parameter int NUM_REQS        = 4,
    parameter int NUM_PORTS       = 1,
    parameter int WORD_SIZE       = 4,
    parameter int CORE_TAG_WIDTH  = 8,
    parameter int DEPTH           = 4,
    parameter int ALM_FULL_MARGIN = 1,
    localparam int REQS_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int WORD_WIDTH     = 8 * WORD_SIZE,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enq_valid,
    input  logic [NUM_PORTS-1:0]                enq_pmask,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0]     enq_data,
    input  logic [NUM_PORTS*REQS_BITS-1:0]      enq_tid,
    input  logic [NUM_PORTS*CORE_TAG_WIDTH-1:0] enq_tag,
    output logic                                alm_full,
    output logic                                rsp_valid,
    output logic [NUM_PORTS-1:0]                rsp_pmask,
    output logic [NUM_PORTS*WORD_WIDTH-1:0]     rsp_data,
    output logic [NUM_PORTS*REQS_BITS-1:0]      rsp_tid,
    output logic [NUM_PORTS*CORE_TAG_WIDTH-1:0] rsp_tag,
    input  logic                                rsp_ready,
    output logic [CNT_W-1:0]                    count,
    output logic                                overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = NUM_PORTS * (1 + WORD_WIDTH + REQS_BITS + CORE_TAG_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALM_THRESH = CNT_W'(DEPTH - ALM_FULL_MARGIN);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;

    logic full;
    logic empty;
    logic enq_req;
    logic enq;
    logic deq;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        deq     = !empty && rsp_ready;
        enq_req = enq_valid && (enq_pmask != '0);
        // A dequeue in the same cycle frees the slot, so a full queue still accepts.
        enq     = enq_req && (!full || deq);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (enq_req && full && !deq);

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= {enq_pmask, enq_data, enq_tid, enq_tag};
        end
    end

    assign {rsp_pmask, rsp_data, rsp_tid, rsp_tag} = mem_q[rd_ptr_q];

    assign rsp_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign alm_full  = (count_q >= ALM_THRESH);

endmodule

// File: tb/tb_core_rsp_queue.sv
// Self-checking bench for core_rsp_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_core_rsp_queue;

    localparam int NUM_REQS        = 4;
    localparam int NUM_PORTS       = 2;
    localparam int WORD_SIZE       = 4;
    localparam int CORE_TAG_WIDTH  = 8;
    localparam int DEPTH           = 4;
    localparam int ALM_FULL_MARGIN = 1;
    localparam int RB              = 2;
    localparam int WW              = 32;
    localparam int CW              = 3;

    typedef struct packed {
        logic [NUM_PORTS-1:0]                pmask;
        logic [NUM_PORTS*WW-1:0]             data;
        logic [NUM_PORTS*RB-1:0]             tid;
        logic [NUM_PORTS*CORE_TAG_WIDTH-1:0] tag;
    } ent_t;

    logic                                clk = 1'b0;
    logic                                reset = 1'b0;
    logic                                enq_valid = 1'b0;
    logic [NUM_PORTS-1:0]                enq_pmask = '0;
    logic [NUM_PORTS*WW-1:0]             enq_data = '0;
    logic [NUM_PORTS*RB-1:0]             enq_tid = '0;
    logic [NUM_PORTS*CORE_TAG_WIDTH-1:0] enq_tag = '0;
    logic                                alm_full;
    logic                                rsp_valid;
    logic [NUM_PORTS-1:0]                rsp_pmask;
    logic [NUM_PORTS*WW-1:0]             rsp_data;
    logic [NUM_PORTS*RB-1:0]             rsp_tid;
    logic [NUM_PORTS*CORE_TAG_WIDTH-1:0] rsp_tag;
    logic                                rsp_ready = 1'b0;
    logic [CW-1:0]                       count;
    logic                                overflow;

    ent_t mq[$];
    logic m_ovf = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    core_rsp_queue #(
        .NUM_REQS(NUM_REQS), .NUM_PORTS(NUM_PORTS), .WORD_SIZE(WORD_SIZE),
        .CORE_TAG_WIDTH(CORE_TAG_WIDTH), .DEPTH(DEPTH), .ALM_FULL_MARGIN(ALM_FULL_MARGIN)
    ) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_pmask(enq_pmask), .enq_data(enq_data),
        .enq_tid(enq_tid), .enq_tag(enq_tag),
        .alm_full(alm_full), .rsp_valid(rsp_valid), .rsp_pmask(rsp_pmask),
        .rsp_data(rsp_data), .rsp_tid(rsp_tid), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready), .count(count), .overflow(overflow)
    );

    function automatic ent_t mk(input logic [7:0] t, input logic [1:0] pm);
        ent_t e;
        e.pmask = pm;
        e.data  = {$urandom, $urandom};
        e.tid   = 4'($urandom);
        e.tag   = {t, t};
        return e;
    endfunction

    // One clock: drive inputs, update the reference model at the edge, settle.
    task automatic cycle(input logic v, input ent_t e, input logic rdy, input logic rst_n);
        logic dq, fl, ok;
        enq_valid = v;
        enq_pmask = e.pmask;
        enq_data  = e.data;
        enq_tid   = e.tid;
        enq_tag   = e.tag;
        rsp_ready = rdy;
        reset     = rst_n;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            dq = (mq.size() != 0) && rdy;
            fl = (mq.size() == DEPTH);
            ok = v && (e.pmask != 0) && (!fl || dq);
            if (v && (e.pmask != 0) && fl && !dq) m_ovf = 1'b1;
            if (dq) void'(mq.pop_front());
            if (ok) mq.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        ent_t z;
        z = '0;
        cycle(1'b0, z, rdy, 1'b1);
    endtask

    task automatic do_reset();
        ent_t z;
        z = '0;
        cycle(1'b0, z, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow got %b want 0", overflow); end
        vecs++; if (alm_full !== 1'b0) begin errs++; $display("FAIL reset_alm_full got %b want 0", alm_full); end
    endtask

    task automatic test_basic();
        ent_t e;
        e = mk(8'h5A, 2'b11);
        e.tid = 4'b01_00;
        cycle(1'b1, e, 1'b0, 1'b1);
        vecs++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b want 1", rsp_valid); end
        vecs++; if (rsp_pmask !== 2'b11) begin errs++; $display("FAIL basic_pmask got %b want 11", rsp_pmask); end
        vecs++; if (rsp_tid !== 4'b0100) begin errs++; $display("FAIL basic_tid got %b want 0100", rsp_tid); end
        vecs++; if (rsp_tag !== 16'h5A5A) begin errs++; $display("FAIL basic_tag got %h want 5a5a", rsp_tag); end
        vecs++; if (rsp_data !== e.data) begin errs++; $display("FAIL basic_data got %h want %h", rsp_data, e.data); end
        vecs++; if (count !== 3'd1) begin errs++; $display("FAIL basic_count got %0d want 1", count); end
        idle(1'b1);
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL basic_drain_valid got %b want 0", rsp_valid); end
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL basic_drain_count got %0d want 0", count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, mk(8'(i), 2'b11), 1'b0, 1'b1);
            vecs++; if (count !== 3'(i + 1)) begin errs++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
            vecs++; if (alm_full !== (i + 1 >= 3)) begin errs++; $display("FAIL fill_alm_full got %b want %b at count %0d", alm_full, (i + 1 >= 3), i + 1); end
        end
        cycle(1'b1, mk(8'hEE, 2'b01), 1'b0, 1'b1);
        vecs++; if (count !== 3'd4) begin errs++; $display("FAIL drop_count got %0d want 4", count); end
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL drop_overflow got %b want 1", overflow); end
        idle(1'b0);
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL overflow_sticky got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (rsp_valid !== 1'b1 || rsp_tag[7:0] !== 8'(i)) begin errs++; $display("FAIL fill_drain_order got v=%b tag=%h want v=1 tag=%h", rsp_valid, rsp_tag[7:0], 8'(i)); end
            idle(1'b1);
        end
        vecs++; if (count !== 3'd0 || overflow !== 1'b1) begin errs++; $display("FAIL fill_after_drain got count=%0d ovf=%b want 0/1", count, overflow); end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp_tags [4];
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(8'(i), 2'b10), 1'b0, 1'b1);
        cycle(1'b1, mk(8'h44, 2'b11), 1'b1, 1'b1);
        vecs++; if (count !== 3'd4) begin errs++; $display("FAIL simul_count got %0d want 4", count); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL simul_overflow got %b want 0", overflow); end
        exp_tags = '{8'h01, 8'h02, 8'h03, 8'h44};
        for (int i = 0; i < 4; i++) begin
            vecs++; if (rsp_valid !== 1'b1 || rsp_tag[7:0] !== exp_tags[i]) begin errs++; $display("FAIL simul_order got v=%b tag=%h want v=1 tag=%h", rsp_valid, rsp_tag[7:0], exp_tags[i]); end
            idle(1'b1);
        end
    endtask

    task automatic test_zero_pmask();
        cycle(1'b1, mk(8'h21, 2'b01), 1'b0, 1'b1);
        cycle(1'b1, mk(8'h99, 2'b00), 1'b0, 1'b1);
        vecs++; if (count !== 3'd1) begin errs++; $display("FAIL zpm_count got %0d want 1", count); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL zpm_overflow got %b want 0", overflow); end
        vecs++; if (rsp_tag !== 16'h2121 || rsp_pmask !== 2'b01) begin errs++; $display("FAIL zpm_head got tag=%h pm=%b want 2121/01", rsp_tag, rsp_pmask); end
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, mk(8'(i), 2'b11), 1'b1, 1'b1);
            vecs++; if (rsp_valid !== 1'b1 || rsp_tag[7:0] !== 8'(i)) begin errs++; $display("FAIL stream_head got v=%b tag=%h want v=1 tag=%h", rsp_valid, rsp_tag[7:0], 8'(i)); end
            vecs++; if (count > 3'd1) begin errs++; $display("FAIL stream_count got %0d want <=1", count); end
        end
        idle(1'b1);
        vecs++; if (rsp_valid !== 1'b0 || overflow !== 1'b0) begin errs++; $display("FAIL stream_end got v=%b ovf=%b want 0/0", rsp_valid, overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(8'(8'h30 + i), 2'b11), 1'b0, 1'b1);
        idle(1'b1);
        vecs++; if (count !== 3'd3 || overflow !== 1'b1) begin errs++; $display("FAIL rmid_pre got count=%0d ovf=%b want 3/1", count, overflow); end
        do_reset();
        vecs++; if (rsp_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || alm_full !== 1'b0) begin
            errs++; $display("FAIL rmid_post got v=%b cnt=%0d ovf=%b af=%b want 0/0/0/0", rsp_valid, count, overflow, alm_full);
        end
        cycle(1'b1, mk(8'h11, 2'b11), 1'b0, 1'b1);
        vecs++; if (rsp_valid !== 1'b1 || rsp_tag !== 16'h1111) begin errs++; $display("FAIL rmid_first got v=%b tag=%h want 1/1111", rsp_valid, rsp_tag); end
        idle(1'b1);
    endtask

    task automatic test_random();
        ent_t e;
        logic v, rdy, rn;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 4);
            rn  = ($urandom_range(0, 79) != 0);
            e   = mk(8'($urandom), 2'($urandom));
            cycle(v, e, rdy, rn);
            vecs++; if (rsp_valid !== (mq.size() != 0)) begin errs++; $display("FAIL rnd_valid got %b want %b", rsp_valid, (mq.size() != 0)); end
            vecs++; if (count !== 3'(mq.size())) begin errs++; $display("FAIL rnd_count got %0d want %0d", count, mq.size()); end
            vecs++; if (overflow !== m_ovf) begin errs++; $display("FAIL rnd_overflow got %b want %b", overflow, m_ovf); end
            vecs++; if (alm_full !== (mq.size() >= DEPTH - ALM_FULL_MARGIN)) begin errs++; $display("FAIL rnd_alm_full got %b want %b", alm_full, (mq.size() >= DEPTH - ALM_FULL_MARGIN)); end
            if (mq.size() != 0) begin
                vecs++; if ({rsp_pmask, rsp_data, rsp_tid, rsp_tag} !== mq[0]) begin
                    errs++; $display("FAIL rnd_payload got %h want %h", {rsp_pmask, rsp_data, rsp_tid, rsp_tag}, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_full_simul();
        test_zero_pmask();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/core_rsp_queue.md
# core_rsp_queue

Per-bank core response queue placed between a cache bank's pipeline output and the core response merge stage. It captures one multi-port response per cycle from the bank with no backpressure on the enqueue side. It presents responses in order through a valid/ready interface on the consumer side. It raises an almost-full flag early enough for the bank to stall before responses are lost.

## Interface

Parameters:

- NUM_REQS, 4: core request lanes; sets tid width REQS_BITS = max(1, clog2(NUM_REQS)).
- NUM_PORTS, 1: ports per bank response.
- WORD_SIZE, 4: word bytes; WORD_WIDTH = 8*WORD_SIZE.
- CORE_TAG_WIDTH, 8: core request tag width.
- DEPTH, 4: entries; power of two, >= 2.
- ALM_FULL_MARGIN, 1: alm_full asserts when count >= DEPTH - ALM_FULL_MARGIN; range 0..DEPTH-1.

Ports:

- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- enq_valid  in  1  bank response present this cycle.
- enq_pmask  in  NUM_PORTS  valid ports within the response.
- enq_data  in  NUM_PORTS*WORD_WIDTH  per-port data.
- enq_tid  in  NUM_PORTS*REQS_BITS  per-port destination lane.
- enq_tag  in  NUM_PORTS*CORE_TAG_WIDTH  per-port core tag.
- alm_full  out  1  bank must stop issuing responses.
- rsp_valid  out  1  head entry valid.
- rsp_pmask  out  NUM_PORTS  head pmask.
- rsp_data  out  NUM_PORTS*WORD_WIDTH  head data.
- rsp_tid  out  NUM_PORTS*REQS_BITS  head tids.
- rsp_tag  out  NUM_PORTS*CORE_TAG_WIDTH  head tags.
- rsp_ready  in  1  consumer accepts head this cycle.
- count  out  clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky; a response was dropped.

## Operation

- Circular buffer with wr_ptr and rd_ptr, each clog2(DEPTH) bits and wrapping modulo DEPTH, plus occupancy counter count in 0..DEPTH.
- Enqueue condition: enq = enq_valid && (enq_pmask != 0) && (!full || deq).
  - enq_valid with pmask==0 is discarded silently; no count change and no overflow.
- Dequeue condition: deq = rsp_valid && rsp_ready. rsp_ready while empty is ignored.
- On enq, the entry {pmask, data, tid, tag} is written at wr_ptr and wr_ptr increments.
- On deq, rd_ptr increments.
- count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- full = (count == DEPTH). empty = (count == 0).
- Full with enq_valid, nonzero pmask and no deq: the entry is dropped and overflow is set.
  - overflow clears only on reset.
- Full with simultaneous deq: the enqueue is accepted and count stays at DEPTH.
- rsp_* are first-word-fall-through from storage[rd_ptr]. rsp_valid = !empty.
- rsp_* payload is don't-care when rsp_valid==0. The bench must not check it.
- alm_full = (count >= DEPTH - ALM_FULL_MARGIN), computed from the registered count.
- Responses leave in strict enqueue order. Entries are never reordered or split.
  - Port-wise partial draining belongs to the merge stage; it holds rsp_ready low until all pmask ports are sent.

## Timing

- Reset (reset==0 at posedge): wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs after reset: rsp_valid=0, count=0, overflow=0, alm_full=(DEPTH-ALM_FULL_MARGIN==0 ? 1 : 0), which is 0 for legal parameters.
- Reset mid-operation discards all stored entries. Storage contents need not be cleared.
- Enqueue latency: an entry written at edge N is visible on rsp_* at cycle N+1. There is no same-cycle bypass when empty.
- Dequeue takes effect at the edge where rsp_valid && rsp_ready. The next entry, if any, is presented in the following cycle.
- Throughput: one enqueue and one dequeue per cycle, sustained, at any occupancy.
- rsp_* stay stable while rsp_valid && !rsp_ready.
- alm_full, count and overflow are registered-state functions with no combinational path from enq_* or rsp_ready.
- Pointer wrap: after DEPTH enqueues wr_ptr returns to 0. Ordering is preserved across the wrap.

## Test plan

- Basic FWFT, DEPTH=4, NUM_PORTS=2: enqueue {pmask=2'b11, tid={1,0}, tag=0x5A} at cycle 0 -> rsp_valid=1 at cycle 1 with the same fields, count=1. rsp_ready=1 at cycle 1 -> rsp_valid=0 and count=0 at cycle 2.
- Fill and almost-full, ALM_FULL_MARGIN=1: 3 enqueues with rsp_ready=0 -> alm_full=1 once count=3. A 4th enqueue -> count=4. A 5th enqueue -> dropped, overflow=1 and sticky, count stays 4. Drain -> tags come out in enqueue order 0..3.
- Full with simultaneous enqueue and dequeue: at count=4 apply enq_valid and rsp_ready together -> count stays 4 and overflow stays 0. The new tag appears as the last entry drained.
- Zero pmask: enq_valid=1 with pmask=0 at count=1 -> count stays 1, overflow=0, head unchanged.
- Wrap and stream: 10 back-to-back enqueues of tags 0..9 with rsp_ready=1 every cycle -> rsp_valid=1 from cycle 1 to cycle 10, tags in order 0..9, count never exceeds 1, overflow=0.
- Reset mid-operation: count=3 and overflow=1, then hold reset=0 for one edge -> rsp_valid=0, count=0, overflow=0, alm_full=0. The next enqueue of tag 0x11 is returned first.
